moment_acc: RTL and testbench

Parametrised streaming moment accumulator for the least-squares fit datapath. It generalises the fixed-256-sample XTX/XTY accumulators into one block. Over a run-time-programmable number of handshaken samples it produces S0 = count, Sx = Σx, Sxx = Σx², Sy = Σy and Sxy = Σxy. Its results feed the matrix-inverse stage directly.

---
 rtl/moment_acc.sv | 259 +++++++++++++++++++++++++
 tb/tb_moment_acc.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moment_acc.sv
// -----------------------------------------------------------------------------
// moment_acc
//
// Streaming moment accumulator for the least-squares fit datapath. Over a
// run of cfg_len handshaken samples (0 meaning 2^N_LOG2) it accumulates
//   s0 = count, sx = sum(x), sy = sum(y), sxx = sum(x*x), sxy = sum(x*y)
// through a two-stage pipeline: stage 1 registers x, y, x*x and x*y, and
// stage 2 adds them into the accumulators. The results feed the
// matrix-inverse stage directly.
//
// Parameters
//   DATA_W : width of x and y (unsigned fixed point)
//   FRAC_W : fractional bits of x and y (informational, no rescaling here)
//   N_LOG2 : log2 of the maximum run length
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   begin a run (honoured in IDLE or DONE only)
//   abort     in   cancel the run in progress (beats start)
//   cfg_len   in   run length, latched when start is accepted
//   in_valid  in   sample present on x / y
//   in_ready  out  block accepts a sample this cycle
//   x, y      in   sample values
//   done      out  one-cycle pulse when the results become valid
//   res_valid out  results valid and held
//   s0        out  accepted-sample count
//   sx, sy    out  sums of x and y (FRAC_W fractional bits)
//   sxx, sxy  out  sums of x*x and x*y (2*FRAC_W fractional bits)
// -----------------------------------------------------------------------------
module moment_acc #(
    parameter int DATA_W = 12,
    parameter int FRAC_W = 4,
    parameter int N_LOG2 = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [N_LOG2-1:0]          cfg_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          x,
    input  logic [DATA_W-1:0]          y,
    output logic                       done,
    output logic                       res_valid,
    output logic [N_LOG2:0]            s0,
    output logic [DATA_W+N_LOG2-1:0]   sx,
    output logic [DATA_W+N_LOG2-1:0]   sy,
    output logic [2*DATA_W+N_LOG2-1:0] sxx,
    output logic [2*DATA_W+N_LOG2-1:0] sxy
);

    localparam int CNT_W  = N_LOG2 + 1;
    localparam int SUM_W  = DATA_W + N_LOG2;
    localparam int PROD_W = 2 * DATA_W;
    localparam int SQ_W   = 2 * DATA_W + N_LOG2;

    // A length code of 0 stands for the full 2^N_LOG2 samples.
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(2 ** N_LOG2);

    // The fixed-point split must fit inside the sample word.
    if (FRAC_W > DATA_W) begin : g_frac_w_check
        $error("moment_acc: FRAC_W must not exceed DATA_W");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [N_LOG2-1:0]   len_q, len_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;       // samples accepted this run
    logic                done_q, done_d;
    logic                res_valid_q, res_valid_d;

    // Decoded per-cycle control strobes
    logic                start_ok;           // start accepted this edge
    logic                accept;             // sample handshake this edge
    logic                flush;              // abort: drop stage-1 contents
    logic [CNT_W-1:0]    target_len;
    logic [CNT_W-1:0]    cnt_inc;

    // -------------------------------------------------------------------------
    // Datapath state
    // -------------------------------------------------------------------------
    logic                v1_q, v1_d;         // stage-1 valid
    logic [DATA_W-1:0]   x1_q, x1_d;
    logic [DATA_W-1:0]   y1_q, y1_d;
    logic [PROD_W-1:0]   xx1_q, xx1_d;
    logic [PROD_W-1:0]   xy1_q, xy1_d;

    logic [CNT_W-1:0]    s0_q, s0_d;
    logic [SUM_W-1:0]    sx_q, sx_d;
    logic [SUM_W-1:0]    sy_q, sy_d;
    logic [SQ_W-1:0]     sxx_q, sxx_d;
    logic [SQ_W-1:0]     sxy_q, sxy_d;

    assign target_len = (len_q == '0) ? MAX_LEN : {1'b0, len_q};
    assign cnt_inc    = cnt_q + CNT_W'(1);

    // -------------------------------------------------------------------------
    // Next-state / control logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so that no path
        // leaves one unassigned and a latch is never inferred.
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        start_ok = 1'b0;
        accept   = 1'b0;
        flush    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // abort has no effect here other than vetoing a start.
                if (start && !abort) begin
                    start_ok = 1'b1;
                    len_d    = cfg_len;
                    cnt_d    = '0;
                    state_d  = ST_ACC;
                end
            end

            ST_ACC: begin
                in_ready = 1'b1;
                if (abort) begin
                    flush   = 1'b1;
                    state_d = ST_IDLE;
                end else if (in_valid) begin
                    accept = 1'b1;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == target_len) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // One cycle lets the last product reach the accumulators.
                if (abort) begin
                    flush   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d      = (state_q == ST_DRAIN) && (state_d == ST_DONE);
        res_valid_d = (state_d == ST_DONE);
    end

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        // Stage 1: capture the sample and its products on a handshake.
        v1_d  = accept;
        x1_d  = x1_q;
        y1_d  = y1_q;
        xx1_d = xx1_q;
        xy1_d = xy1_q;
        if (accept) begin
            x1_d  = x;
            y1_d  = y;
            xx1_d = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, x};
            xy1_d = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
        end

        // Stage 2: accumulate. Guard bits make every sum exact.
        s0_d  = s0_q;
        sx_d  = sx_q;
        sy_d  = sy_q;
        sxx_d = sxx_q;
        sxy_d = sxy_q;
        if (start_ok) begin
            s0_d  = '0;
            sx_d  = '0;
            sy_d  = '0;
            sxx_d = '0;
            sxy_d = '0;
        end else if (v1_q && !flush) begin
            s0_d  = s0_q + CNT_W'(1);
            sx_d  = sx_q + {{N_LOG2{1'b0}}, x1_q};
            sy_d  = sy_q + {{N_LOG2{1'b0}}, y1_q};
            sxx_d = sxx_q + {{N_LOG2{1'b0}}, xx1_q};
            sxy_d = sxy_q + {{N_LOG2{1'b0}}, xy1_q};
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: the pipeline data registers are reset along with the control
    // state; they are a handful of flops, and a clean reset keeps the
    // outputs and stage-1 contents deterministic after a mid-run reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            v1_q        <= 1'b0;
            x1_q        <= '0;
            y1_q        <= '0;
            xx1_q       <= '0;
            xy1_q       <= '0;
            s0_q        <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            sxx_q       <= '0;
            sxy_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            v1_q        <= v1_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            xx1_q       <= xx1_d;
            xy1_q       <= xy1_d;
            s0_q        <= s0_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            sxx_q       <= sxx_d;
            sxy_q       <= sxy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign done      = done_q;
    assign res_valid = res_valid_q;
    assign s0        = s0_q;
    assign sx        = sx_q;
    assign sy        = sy_q;
    assign sxx       = sxx_q;
    assign sxy       = sxy_q;

endmodule

// File: tb/tb_moment_acc.sv
// -----------------------------------------------------------------------------
// tb_moment_acc
//
// Directed and randomized scenarios for moment_acc. Inputs are driven and
// outputs observed at the falling clock edge; the DUT updates on the rising
// edge. Expected sums come from plain arithmetic over the sample arrays the
// bench itself presents.
// -----------------------------------------------------------------------------
module tb_moment_acc;

    localparam int DATA_W = 12;
    localparam int FRAC_W = 4;
    localparam int N_LOG2 = 8;
    localparam int MAXN   = 2 ** N_LOG2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic                       abort;
    logic [N_LOG2-1:0]          cfg_len;
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          x;
    logic [DATA_W-1:0]          y;
    logic                       done;
    logic                       res_valid;
    logic [N_LOG2:0]            s0;
    logic [DATA_W+N_LOG2-1:0]   sx;
    logic [DATA_W+N_LOG2-1:0]   sy;
    logic [2*DATA_W+N_LOG2-1:0] sxx;
    logic [2*DATA_W+N_LOG2-1:0] sxy;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [DATA_W-1:0] qx [MAXN];
    logic [DATA_W-1:0] qy [MAXN];

    moment_acc #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .N_LOG2 (N_LOG2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .done      (done),
        .res_valid (res_valid),
        .s0        (s0),
        .sx        (sx),
        .sy        (sy),
        .sxx       (sxx),
        .sxy       (sxy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the moments of the first n entries of the sample arrays.
    task automatic check_results(input string tag, input int n);
        longint ex, ey, exx, exy;
        ex = 0; ey = 0; exx = 0; exy = 0;
        for (int i = 0; i < n; i++) begin
            ex  += longint'(qx[i]);
            ey  += longint'(qy[i]);
            exx += longint'(qx[i]) * longint'(qx[i]);
            exy += longint'(qx[i]) * longint'(qy[i]);
        end
        check({tag, ".s0"},  s0,  n);
        check({tag, ".sx"},  sx,  ex);
        check({tag, ".sy"},  sy,  ey);
        check({tag, ".sxx"}, sxx, exx);
        check({tag, ".sxy"}, sxy, exy);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".in_ready"},  in_ready,  0);
        check({tag, ".done"},      done,      0);
        check({tag, ".res_valid"}, res_valid, 0);
        check({tag, ".s0"},  s0,  0);
        check({tag, ".sx"},  sx,  0);
        check({tag, ".sy"},  sy,  0);
        check({tag, ".sxx"}, sxx, 0);
        check({tag, ".sxy"}, sxy, 0);
    endtask

    // Pulse start for one edge and confirm the fresh run is open and cleared.
    task automatic do_start(input logic [N_LOG2-1:0] len, input string tag);
        cfg_len = len;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".start.in_ready"},  in_ready,  1);
        check({tag, ".start.res_valid"}, res_valid, 0);
        check({tag, ".start.done"},      done,      0);
        check({tag, ".start.s0"},        s0,        0);
        check({tag, ".start.sxx"},       sxx,       0);
    endtask

    // Present n samples (optionally with random gaps and an ignored start
    // pulse at sample start_at), then check the drain and done cycles.
    // Returns at the falling edge inside the done-pulse cycle.
    task automatic run(input int n, input bit gaps, input int start_at, input string tag);
        int k;
        int cyc;
        bit v;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 20 * n + 50) begin
            v        = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
            in_valid = v;
            x        = qx[k];
            y        = qy[k];
            start    = (k == start_at);
            if (k == start_at) cfg_len = 8'd1;
            @(negedge clk);
            cyc++;
            if (v) k++;
            // After the final acceptance the block must stop taking samples.
            check({tag, ".in_ready"}, in_ready, (k < n));
            check({tag, ".no_early_done"}, done, 0);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (k != n) check({tag, ".feed_timeout"}, k, n);
        check({tag, ".drain.res_valid"}, res_valid, 0);
        @(negedge clk);
        check({tag, ".done"},           done,      1);
        check({tag, ".res_valid"},      res_valid, 1);
        check({tag, ".done.in_ready"},  in_ready,  0);
        check_results(tag, n);
    endtask

    // One cycle after the done pulse: pulse gone, results held.
    task automatic check_hold(input string tag, input int n);
        @(negedge clk);
        check({tag, ".hold.done"},      done,      0);
        check({tag, ".hold.res_valid"}, res_valid, 1);
        check({tag, ".hold.in_ready"},  in_ready,  0);
        check_results({tag, ".hold"}, n);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        cfg_len  = '0;
        in_valid = 1'b0;
        x        = '0;
        y        = '0;

        // ---------------- reset state ----------------
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- start with abort in IDLE ----------------
        start = 1'b1; abort = 1'b1; cfg_len = 8'd4;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("idle_start_abort.in_ready", in_ready, 0);
        @(negedge clk);
        check("idle_start_abort.in_ready2", in_ready, 0);
        check("idle_start_abort.res_valid", res_valid, 0);

        // ---------------- S1: len 4, x=1.0, y=2.0 ----------------
        for (int i = 0; i < 4; i++) begin qx[i] = 12'd16; qy[i] = 12'd32; end
        do_start(8'd4, "s1");
        run(4, 1'b0, -1, "s1");
        check_hold("s1", 4);
        @(negedge clk);
        check("s1.hold2.res_valid", res_valid, 1);

        // start+abort in DONE: abort vetoes, results stay
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("done_start_abort.res_valid", res_valid, 1);
        check("done_start_abort.s0", s0, 4);
        check("done_start_abort.in_ready", in_ready, 0);

        // ---------------- S2: full length, max values ----------------
        for (int i = 0; i < MAXN; i++) begin qx[i] = 12'hFFF; qy[i] = 12'hFFF; end
        do_start(8'd0, "s2");
        run(MAXN, 1'b0, -1, "s2");
        check_hold("s2", MAXN);

        // ---------------- S3: x=1..8, y=2x, gap-free then gapped ----------------
        for (int i = 0; i < 8; i++) begin
            qx[i] = 12'(i + 1);
            qy[i] = 12'(2 * (i + 1));
        end
        do_start(8'd8, "s3a");
        run(8, 1'b0, -1, "s3a");
        check_hold("s3a", 8);
        do_start(8'd8, "s3b");
        run(8, 1'b1, -1, "s3b");
        check_hold("s3b", 8);

        // ---------------- S4: abort after 3 samples ----------------
        for (int i = 0; i < 10; i++) begin
            qx[i] = 12'($urandom_range(0, 4095));
            qy[i] = 12'($urandom_range(0, 4095));
        end
        do_start(8'd10, "s4");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; x = qx[i]; y = qy[i];
            @(negedge clk);
        end
        abort = 1'b1; in_valid = 1'b1; x = qx[3]; y = qy[3];
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        check("s4.abort.in_ready",  in_ready,  0);
        check("s4.abort.done",      done,      0);
        check("s4.abort.res_valid", res_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s4.after.done",      done,      0);
            check("s4.after.res_valid", res_valid, 0);
            check("s4.after.in_ready",  in_ready,  0);
        end
        qx[0] = 12'd1; qy[0] = 12'd1; qx[1] = 12'd1; qy[1] = 12'd1;
        do_start(8'd2, "s4b");
        run(2, 1'b0, -1, "s4b");
        check_hold("s4b", 2);

        // ---------------- S5: ignored start in ACC, back-to-back start ----------------
        for (int i = 0; i < 4; i++) begin
            qx[i] = 12'($urandom_range(0, 4095));
            qy[i] = 12'($urandom_range(0, 4095));
        end
        do_start(8'd4, "s5a");
        run(4, 1'b0, 2, "s5a");
        // Still inside the done-pulse cycle: start again right away.
        for (int i = 0; i < 2; i++) begin
            qx[i] = 12'($urandom_range(0, 4095));
            qy[i] = 12'($urandom_range(0, 4095));
        end
        do_start(8'd2, "s5b");
        run(2, 1'b0, -1, "s5b");
        check_hold("s5b", 2);

        // ---------------- S6: asynchronous reset mid-ACC ----------------
        for (int i = 0; i < 4; i++) begin qx[i] = 12'd16; qy[i] = 12'd32; end
        do_start(8'd4, "s6");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; x = qx[i]; y = qy[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("s6.pre_reset.s0", s0, 2);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("s6.reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("s6.post.done", done, 0);
        do_start(8'd4, "s6b");
        run(4, 1'b0, -1, "s6b");
        check_hold("s6b", 4);

        // ---------------- S7: random length, random data, random gaps ----------------
        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                qx[i] = 12'($urandom_range(0, 4095));
                qy[i] = 12'($urandom_range(0, 4095));
            end
            do_start(8'(n), "s7");
            run(n, 1'b1, -1, "s7");
            check_hold("s7", n);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
